// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer.
//   note_t      : one melody table entry {half_period, volume, dur}
//   seq_state_e : sequencer FSM states
//   SONG        : default 16-entry melody for a 25 MHz clock, 1 ms ticks
package tone_pkg;

  typedef struct packed {
    logic [15:0] half_period;  // clocks per half cycle, 0 = rest
    logic [2:0]  volume;       // 0..7
    logic [9:0]  dur;          // ticks, 0 = end of song
  } note_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_OFFER  = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_OFFER  = ST_OFFER,
    S_PLAY   = ST_PLAY,
    S_GAP    = ST_GAP,
    S_FINISH = ST_FINISH
  } seq_state_e;

  localparam int unsigned DEFAULT_SONG_LEN = 16;

  // Ascending range so the first listed entry is index 0.
  localparam note_t [0:DEFAULT_SONG_LEN-1] SONG = {
    {16'd23900, 3'd5, 10'd250},  // C5
    {16'd21294, 3'd5, 10'd250},  // D5
    {16'd18968, 3'd5, 10'd250},  // E5
    {16'd23900, 3'd5, 10'd250},  // C5
    {16'd0,     3'd0, 10'd100},  // rest
    {16'd18968, 3'd6, 10'd250},  // E5
    {16'd17896, 3'd6, 10'd250},  // F5
    {16'd15944, 3'd6, 10'd500},  // G5
    {16'd0,     3'd0, 10'd100},  // rest
    {16'd15944, 3'd7, 10'd125},  // G5
    {16'd14205, 3'd7, 10'd125},  // A5
    {16'd15944, 3'd7, 10'd125},  // G5
    {16'd17896, 3'd6, 10'd125},  // F5
    {16'd18968, 3'd5, 10'd250},  // E5
    {16'd23900, 3'd4, 10'd500},  // C5
    {16'd0,     3'd0, 10'd0}     // end marker
  };

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
//   i_Clk   : system clock (state updates on falling edge)
//   i_Reset : synchronous active-high reset
//   i_Clear : synchronous clear, holds the counter at 0
//   o_Tick  : high while the counter sits at DIV-1 (the wrap cycle)
module tick_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(negedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign o_Tick = (count == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Walks a constant melody table and hands one note at a time to the
// square-wave tone generator, holding each for its duration and muting
// the generator for a fixed gap between notes.
//   i_Clk, i_Reset          : clock (falling edge), sync active-high reset
//   i_Start, i_Stop         : begin song from entry 0 / abort (stop wins)
//   o_Half_Period, o_Volume : current note fields
//   o_Note_Valid, i_Note_Ready : note handshake
//   o_Mute                  : generator must output 0
//   o_Busy, o_Done          : not idle / one-cycle song-complete pulse
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned SONG_LEN  = 16,
  parameter int unsigned GAP_TICKS = 20,
  parameter note_t [0:SONG_LEN-1] SONG_TABLE = SONG
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic        i_Stop,
  output logic [15:0] o_Half_Period,
  output logic [2:0]  o_Volume,
  output logic        o_Note_Valid,
  input  logic        i_Note_Ready,
  output logic        o_Mute,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned IDX_W    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int unsigned GAP_W    = $clog2(GAP_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  seq_state_e       state;
  logic [IDX_W-1:0] index;
  logic [9:0]       duration;
  logic [GAP_W-1:0] gap_cnt;
  note_t            rom_q;
  logic             rom_loaded;
  logic             tick;
  logic             presc_clear;

  // Ticks only run while timing a note or a gap; clearing elsewhere makes
  // the first tick land exactly TICK_DIV clocks after the handshake edge.
  assign presc_clear = !((state == S_PLAY) || (state == S_GAP));

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_Clear(presc_clear),
    .o_Tick (tick)
  );

  assign o_Busy = (state != S_IDLE);
  assign o_Done = (state == S_FINISH);

  always_ff @(negedge i_Clk) begin
    if (i_Reset) begin
      state         <= S_IDLE;
      index         <= '0;
      duration      <= '0;
      gap_cnt       <= '0;
      rom_q         <= '0;
      rom_loaded    <= 1'b0;
      o_Half_Period <= '0;
      o_Volume      <= '0;
      o_Note_Valid  <= 1'b0;
      o_Mute        <= 1'b1;
    end else if (i_Stop && (state != S_IDLE)) begin
      state        <= S_IDLE;
      rom_loaded   <= 1'b0;
      o_Note_Valid <= 1'b0;
      o_Mute       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Start && !i_Stop) begin
            state      <= S_FETCH;
            index      <= '0;
            rom_loaded <= 1'b0;
          end
        end
        // Table read is registered on the first FETCH edge and decoded on
        // the second, so a note is offered two edges after start.
        S_FETCH: begin
          if (!rom_loaded) begin
            rom_q      <= SONG_TABLE[index];
            rom_loaded <= 1'b1;
          end else begin
            rom_loaded <= 1'b0;
            if (rom_q.dur == '0) begin
              state <= S_FINISH;
            end else begin
              state         <= S_OFFER;
              o_Note_Valid  <= 1'b1;
              o_Half_Period <= rom_q.half_period;
              o_Volume      <= rom_q.volume;
            end
          end
        end
        S_OFFER: begin
          if (i_Note_Ready) begin
            state        <= S_PLAY;
            o_Note_Valid <= 1'b0;
            o_Mute       <= 1'b0;
            duration     <= rom_q.dur;
          end
        end
        S_PLAY: begin
          if (tick) begin
            duration <= duration - 10'd1;
            if (duration == 10'd1) begin
              state   <= S_GAP;
              o_Mute  <= 1'b1;
              gap_cnt <= GAP_W'(GAP_TICKS);
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) begin
              if (index == LAST_IDX) begin
                state <= S_FINISH;
              end else begin
                index <= index + IDX_W'(1);
                state <= S_FETCH;
              end
            end
          end
        end
        S_FINISH: begin
          o_Mute <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer. Each start pushes the notes the
// song should produce (fields, mute-low length) plus a done marker; a
// monitor pops and compares on every handshake and done pulse.
module tb_tone_sequencer;
  import tone_pkg::*;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned TICK_HZ   = 100;
  localparam int unsigned TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned GAP_TICKS = 2;
  localparam int unsigned SONG_LEN  = 4;
  // Mute high from gap start to next valid: gap ticks plus two FETCH edges.
  localparam int GAP_CLKS = GAP_TICKS * TICK_DIV + 2;

  localparam note_t [0:SONG_LEN-1] TB_SONG = {
    {16'd100, 3'd7, 10'd3},
    {16'd0,   3'd0, 10'd1},
    {16'd50,  3'd3, 10'd2},
    {16'd0,   3'd0, 10'd0}
  };
  localparam int SONG_HP  [SONG_LEN] = '{100, 0, 50, 0};
  localparam int SONG_VOL [SONG_LEN] = '{7, 0, 3, 0};
  localparam int SONG_DUR [SONG_LEN] = '{3, 1, 2, 0};

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ready = 1'b1;
  logic        ready_force = 1'b1;
  logic        rand_ready = 1'b0;
  logic [15:0] half;
  logic [2:0]  vol;
  logic        valid, mute, busy, done;

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SONG_LEN(SONG_LEN),
    .GAP_TICKS(GAP_TICKS), .SONG_TABLE(TB_SONG)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Stop(stop),
    .o_Half_Period(half), .o_Volume(vol), .o_Note_Valid(valid),
    .i_Note_Ready(ready), .o_Mute(mute), .o_Busy(busy), .o_Done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int hp;
    int vol;
    int len;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the active (falling) edge; outputs are read
  // on the rising edge, midway between active edges.
  task automatic drv();
    @(negedge clk);
    #1;
  endtask

  task automatic smp();
    @(posedge clk);
  endtask

  // Reference model: notes play in table order until the end marker.
  task automatic push_song();
    exp_t e;
    for (int i = 0; i < int'(SONG_LEN); i++) begin
      if (SONG_DUR[i] == 0) break;
      e.is_done = 1'b0;
      e.hp      = SONG_HP[i];
      e.vol     = SONG_VOL[i];
      e.len     = SONG_DUR[i] * int'(TICK_DIV);
      expq.push_back(e);
    end
    e.is_done = 1'b1;
    e.hp = 0; e.vol = 0; e.len = 0;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    #2;
    ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- monitor ----------------
  bit          measuring = 1'b0;
  bit          gap_meas = 1'b0;
  int          mute_cnt, exp_len, gap_cnt;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic        prev_stop = 1'b0, prev_rst = 1'b1;
  logic [15:0] prev_half = '0;
  logic [2:0]  prev_vol = '0;

  always @(posedge clk) begin
    exp_t e;
    bit   front_note, front_done;
    if (rst) begin
      measuring = 1'b0;
      gap_meas  = 1'b0;
    end else begin
      if (gap_meas) begin
        gap_cnt++;
        if (valid && !prev_valid) begin
          chk("gap_len", gap_cnt, GAP_CLKS);
          gap_meas = 1'b0;
        end
      end
      if (measuring) begin
        if (!mute) begin
          mute_cnt++;
        end else begin
          chk("note_len", mute_cnt, exp_len);
          measuring = 1'b0;
          if (expq.size() > 0 && !expq[0].is_done) begin
            gap_meas = 1'b1;
            gap_cnt  = 0;
          end
        end
      end
      if (prev_valid && !prev_ready && !prev_stop && !prev_rst) begin
        chk("hold_valid", valid, 1);
        chk("hold_fields", {half, vol}, {prev_half, prev_vol});
      end
      if (valid && ready && !stop) begin
        chk("offer_mute", mute, 1);
        front_note = (expq.size() > 0) && !expq[0].is_done;
        chk("note_pending", front_note, 1);
        if (front_note) begin
          e = expq.pop_front();
          chk("half_period", half, e.hp);
          chk("volume", vol, e.vol);
          exp_len   = e.len;
          mute_cnt  = 0;
          measuring = 1'b1;
        end
      end
      if (done) begin
        chk("done_pulse", prev_done, 0);
        front_done = (expq.size() > 0) && expq[0].is_done;
        chk("done_pending", front_done, 1);
        if (front_done) void'(expq.pop_front());
      end
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_done  = done;
    prev_stop  = stop;
    prev_rst   = rst;
    prev_half  = half;
    prev_vol   = vol;
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_values(input string tag);
    chk({tag, "_half"}, half, 0);
    chk({tag, "_vol"}, vol, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_mute"}, mute, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Pulse start for one active edge N; note must be valid after N+2.
  task automatic start_song();
    push_song();
    drv();
    start = 1'b1;
    drv();
    start = 1'b0;
    smp();
    chk("lat_busy", busy, 1);
    chk("lat_valid_n", valid, 0);
    smp();
    chk("lat_valid_n1", valid, 0);
    smp();
    chk("lat_valid_n2", valid, 1);
  endtask

  task automatic wait_song(input string tag);
    int n = 0;
    while ((busy || expq.size() != 0) && n < 2000) begin
      smp();
      n++;
    end
    chk(tag, (n < 2000), 1);
  endtask

  initial begin
    int  n;
    bit  seen_done;

    repeat (3) drv();
    rst = 1'b0;
    smp();
    check_reset_values("reset");

    // Normal song, ready tied high.
    start_song();
    wait_song("normal_timeout");
    chk("normal_idle", busy, 0);

    // Backpressure in OFFER.
    ready_force = 1'b0;
    start_song();
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("bp_valid", valid, 1);
      chk("bp_half", half, 100);
      chk("bp_vol", vol, 7);
    end
    drv();
    ready_force = 1'b1;
    smp();
    smp();
    chk("bp_play_mute", mute, 0);
    chk("bp_play_valid", valid, 0);
    wait_song("bp_timeout");

    // Random ready with start pulses while busy (must be ignored).
    for (int run = 0; run < 4; run++) begin
      rand_ready = 1'b1;
      start_song();
      n = 0;
      while ((busy || expq.size() != 0) && n < 2000) begin
        drv();
        start = busy && ($urandom_range(0, 5) == 0);
        n++;
      end
      start = 1'b0;
      chk("rand_timeout", (n < 2000), 1);
      rand_ready = 1'b0;
    end

    // Stop in the middle of note2.
    start_song();
    n = 0;
    while (!(expq.size() == 1 && measuring && !mute) && n < 400) begin
      smp();
      n++;
    end
    chk("reach_note2", (n < 400), 1);
    repeat (5) drv();
    stop = 1'b1;
    expq.delete();
    measuring = 1'b0;
    gap_meas  = 1'b0;
    drv();
    stop = 1'b0;
    smp();
    chk("stop_busy", busy, 0);
    chk("stop_mute", mute, 1);
    chk("stop_valid", valid, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      smp();
      seen_done |= done;
    end
    chk("stop_no_done", seen_done, 0);
    start_song();
    wait_song("replay_timeout");

    // Start and stop together in IDLE.
    drv();
    start = 1'b1;
    stop  = 1'b1;
    drv();
    start = 1'b0;
    stop  = 1'b0;
    smp();
    chk("ss_busy", busy, 0);
    smp();
    smp();
    chk("ss_valid", valid, 0);

    // Reset while in GAP after note0.
    start_song();
    n = 0;
    while (!(expq.size() == 3 && !measuring && gap_meas) && n < 400) begin
      smp();
      n++;
    end
    chk("reach_gap", (n < 400), 1);
    repeat (5) drv();
    rst = 1'b1;
    expq.delete();
    measuring = 1'b0;
    gap_meas  = 1'b0;
    drv();
    rst = 1'b0;
    smp();
    check_reset_values("gap_reset");
    start_song();
    wait_song("post_reset_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
